// File: rtl/bch_pkg.sv
// Shared GF(2^m) helpers and field constants for the BCH datapath.
// All functions are elaboration-time only and build constant matrices.
package bch_pkg;

  localparam logic [6:0]  PRIM_POLY_M6  = 7'h43;
  localparam logic [8:0]  PRIM_POLY_M8  = 9'h11D;
  localparam logic [10:0] PRIM_POLY_M10 = 11'h409;

  localparam int GF_MAX_M = 16;

  typedef logic [GF_MAX_M-1:0] gf_elem_t;

  function automatic gf_elem_t gf_const_mul(
    gf_elem_t a,
    int       e,
    int       m,
    int       poly
  );
    gf_elem_t r;
    gf_elem_t mask;
    int       n;
    mask = gf_elem_t'((1 << m) - 1);
    r    = a & mask;
    n    = e % ((1 << m) - 1);
    for (int i = 0; i < n; i++) begin
      if (r[m-1])
        r = ((r << 1) ^ gf_elem_t'(poly)) & mask;
      else
        r = (r << 1) & mask;
    end
    return r;
  endfunction

  function automatic gf_elem_t gf_alpha_pow(
    int e,
    int m,
    int poly
  );
    return gf_const_mul(gf_elem_t'(1), e, m, poly);
  endfunction

endpackage

// File: rtl/bch_syndrome_stream_if.sv
// Codeword-in / syndrome-out handshake bundle.
// The slave side is the syndrome engine.
interface bch_syndrome_stream_if
  import bch_pkg::*;
#(
  parameter int DW = 64,
  parameter int SW = 80
);

  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          in_last;
  logic          syn_valid;
  logic          syn_ready;
  logic [SW-1:0] syn_data;
  logic          syn_zero;
  logic          syn_err;

  modport master (
    output in_valid,
    output in_data,
    output in_last,
    output syn_ready,
    input  in_ready,
    input  syn_valid,
    input  syn_data,
    input  syn_zero,
    input  syn_err
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_last,
    input  syn_ready,
    output in_ready,
    output syn_valid,
    output syn_data,
    output syn_zero,
    output syn_err
  );

endinterface

// File: rtl/bch_gf_const_mul.sv
// Combinational multiply by the constant alpha^E in GF(2^M).
// Each output bit is the parity of the input under a fixed mask.
module bch_gf_const_mul
  import bch_pkg::*;
#(
  parameter int         M         = 10,
  parameter logic [M:0] PRIM_POLY = 11'h409,
  parameter int         E         = 1
) (
  input  logic [M-1:0] a,
  output logic [M-1:0] y
);

  // Row b collects bit b of alpha^(E+i) over every input bit i.
  function automatic logic [M-1:0] row_mask(int b);
    logic [M-1:0] r;
    gf_elem_t     c;
    r = '0;
    for (int i = 0; i < M; i++) begin
      c = gf_const_mul(gf_elem_t'(1) << i, E,
                       M, int'(PRIM_POLY));
      r[i] = c[b];
    end
    return r;
  endfunction

  for (genvar b = 0; b < M; b++) begin : g_bit
    localparam logic [M-1:0] MASK = row_mask(b);
    assign y[b] = ^(a & MASK);
  end

endmodule

// File: rtl/bch_syndrome_stream.sv
// Streaming BCH syndrome engine: parallel Horner update of S1..S2T
// per beat, with a one-deep output register toward Berlekamp-Massey.
module bch_syndrome_stream
  import bch_pkg::*;
#(
  parameter int         M         = 10,
  parameter logic [M:0] PRIM_POLY = 11'h409,
  parameter int         N         = 1023,
  parameter int         T         = 4,
  parameter int         P         = 8,
  parameter int         SYM_W     = 8
) (
  input logic                  clk,
  input logic                  rstn,
  bch_syndrome_stream_if.slave bus
);

  localparam int BEATS = (N + P - 1) / P;
  localparam int PAD   = BEATS * P - N;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

  logic [CW-1:0]             beat_cnt;
  logic [2*T-1:0][M-1:0]     acc;
  logic [2*T-1:0][M-1:0]     acc_sh;
  logic [2*T-1:0][M-1:0]     acc_nxt;
  logic [P-1:0]              hard;
  logic                      first;
  logic                      at_end;
  logic                      fire;
  logic                      frame_end;
  logic                      len_err;
  logic                      nxt_zero;
  logic                      unused_soft;

  assign unused_soft = ^bus.in_data;

  assign first  = (beat_cnt == '0);
  assign at_end = bus.in_last
                | (beat_cnt == LAST_BEAT);

  // Only a frame-ending beat can collide with a held result.
  assign bus.in_ready = !(at_end
                       && bus.syn_valid
                       && !bus.syn_ready);

  assign fire      = bus.in_valid & bus.in_ready;
  assign frame_end = fire & at_end;
  assign len_err   = !(bus.in_last
                    && beat_cnt == LAST_BEAT);
  assign nxt_zero  = (acc_nxt == '0);

  for (genvar k = 0; k < P; k++) begin : g_hard
    localparam bit IS_PAD = (k >= P - PAD);
    assign hard[k] = bus.in_data[k*SYM_W + SYM_W - 1]
                   & !(first && IS_PAD);
  end

  for (genvar j = 0; j < 2*T; j++) begin : g_syn
    logic [M-1:0] term [P];
    logic [M-1:0] sum;

    bch_gf_const_mul #(
      .M         (M),
      .PRIM_POLY (PRIM_POLY),
      .E         ((j + 1) * P)
    ) u_step (
      .a (acc[j]),
      .y (acc_sh[j])
    );

    for (genvar k = 0; k < P; k++) begin : g_lane
      bch_gf_const_mul #(
        .M         (M),
        .PRIM_POLY (PRIM_POLY),
        .E         ((j + 1) * k)
      ) u_tap (
        .a (M'(hard[k])),
        .y (term[k])
      );
    end

    // First beat starts from zero, so no clear cycle is needed.
    always_comb begin
      sum = first ? '0 : acc_sh[j];
      for (int k = 0; k < P; k++)
        sum = sum ^ term[k];
    end

    assign acc_nxt[j] = sum;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      beat_cnt      <= '0;
      acc           <= '0;
      bus.syn_valid <= 1'b0;
      bus.syn_data  <= '0;
      bus.syn_zero  <= 1'b0;
      bus.syn_err   <= 1'b0;
    end else begin
      if (fire) begin
        acc      <= acc_nxt;
        beat_cnt <= at_end ? '0 : beat_cnt + 1'b1;
      end
      if (frame_end) begin
        bus.syn_valid <= 1'b1;
        bus.syn_data  <= acc_nxt;
        bus.syn_zero  <= nxt_zero;
        bus.syn_err   <= len_err;
      end else if (bus.syn_ready) begin
        bus.syn_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bch_syndrome_stream.sv
// Randomised bench for bch_syndrome_stream against a direct
// sum-of-powers syndrome model, plus the directed corner cases.
module tb_bch_syndrome_stream;

  localparam int M     = 10;
  localparam int N     = 1023;
  localparam int T     = 4;
  localparam int P     = 8;
  localparam int SYM_W = 8;
  localparam int BEATS = 128;
  localparam int PAD   = 1;
  localparam int Q     = 1023;
  localparam int DW    = P * SYM_W;
  localparam int SW    = 2 * T * M;
  localparam int TMO   = 400;

  typedef logic [SW+1:0] out_t;

  logic clk  = 1'b0;
  logic rstn = 1'b0;

  always #5 clk = ~clk;

  bch_syndrome_stream_if #(.DW(DW), .SW(SW)) bus ();
  bch_syndrome_stream_if #(.DW(64), .SW(24)) bus6 ();

  bch_syndrome_stream #(
    .M(M), .PRIM_POLY(11'h409), .N(N),
    .T(T), .P(P), .SYM_W(SYM_W)
  ) dut (
    .clk(clk), .rstn(rstn), .bus(bus)
  );

  bch_syndrome_stream #(
    .M(6), .PRIM_POLY(7'h43), .N(63),
    .T(2), .P(8), .SYM_W(8)
  ) dut6 (
    .clk(clk), .rstn(rstn), .bus(bus6)
  );

  int errs   = 0;
  int checks = 0;

  task automatic check(
    input string        tag,
    input logic [127:0] got,
    input logic [127:0] exp
  );
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  out_t          exp_q[$];
  int            exp_t[Q];
  logic [DW-1:0] fr[BEATS];
  int            cur_beat     = -1;
  int            early_stalls = 0;
  int            rdy_mode     = 1;

  // S_j = sum over set received bits of alpha^(j*degree).
  function automatic out_t model(input int nb, input bit last);
    logic [M-1:0]  s[2*T];
    logic [SW-1:0] d;
    int            deg;
    for (int j = 0; j < 2*T; j++) s[j] = '0;
    for (int b = 0; b < nb; b++)
      for (int k = 0; k < P; k++)
        if (fr[b][k*SYM_W+SYM_W-1] && !(b == 0 && k >= P-PAD)) begin
          deg = (nb - 1 - b) * P + k;
          for (int j = 0; j < 2*T; j++)
            s[j] ^= M'(exp_t[((j + 1) * deg) % Q]);
        end
    for (int j = 0; j < 2*T; j++) d[j*M +: M] = s[j];
    return {d == '0, !(nb == BEATS && last), d};
  endfunction

  task automatic drive_frame(
    input int nb,
    input bit last,
    input int gap_pct,
    input int abort_at
  );
    bit ok;
    int n;
    for (int i = 0; i < nb; i++) begin
      if (i == abort_at) begin
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        cur_beat     = -1;
        return;
      end
      while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
        bus.in_valid = 1'b0;
        bus.in_data  = {$urandom, $urandom};
        bus.in_last  = 1'($urandom);
        @(posedge clk); #1;
      end
      cur_beat     = i;
      bus.in_valid = 1'b1;
      bus.in_data  = fr[i];
      bus.in_last  = (i == nb - 1) && (nb < BEATS || last);
      ok = 1'b0;
      n  = 0;
      while (!ok) begin
        @(negedge clk);
        ok = bus.in_ready;
        if (!ok && i < BEATS - 1) early_stalls++;
        if (ok && i == nb - 1) exp_q.push_back(model(nb, last));
        @(posedge clk); #1;
        if (!ok && ++n > TMO) begin
          check("accept_timeout", 0, 1);
          bus.in_valid = 1'b0;
          cur_beat     = -1;
          return;
        end
      end
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    cur_beat     = -1;
    check("latency", bus.syn_valid, 1);
  endtask

  task automatic drive6(input logic [63:0] d0, input logic [63:0] d7);
    for (int i = 0; i < 8; i++) begin
      bus6.in_valid = 1'b1;
      bus6.in_data  = (i == 0) ? d0 : (i == 7) ? d7 : 64'h0;
      bus6.in_last  = (i == 7);
      @(posedge clk); #1;
    end
    bus6.in_valid = 1'b0;
    bus6.in_last  = 1'b0;
  endtask

  task automatic fill(input logic [7:0] sym);
    for (int b = 0; b < BEATS; b++) fr[b] = {P{sym}};
  endtask

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rdy_mode == 2) bus.syn_ready = 1'($urandom);
      else               bus.syn_ready = (rdy_mode == 1);
    end
  end

  initial begin
    out_t cur;
    out_t held;
    bit   held_ok;
    held_ok = 1'b0;
    forever begin
      @(negedge clk);
      if (!rstn || !bus.syn_valid) begin
        held_ok = 1'b0;
      end else begin
        cur = {bus.syn_zero, bus.syn_err, bus.syn_data};
        if (held_ok) check("hold", cur, held);
        if (bus.syn_ready) begin
          held_ok = 1'b0;
          if (exp_q.size() == 0) check("spurious_set", 1, 0);
          else check("syn_set", cur, exp_q.pop_front());
        end else begin
          held    = cur;
          held_ok = 1'b1;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    check("watchdog", 0, 1);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [SW-1:0] ones_v;
    logic [SW-1:0] t3_v;
    int            a;
    int            n;
    int            nb;
    int            kind;
    bit            last;

    a = 1;
    for (int i = 0; i < Q; i++) begin
      exp_t[i] = a;
      a = a << 1;
      if ((a & 1024) != 0) a = a ^ 'h409;
    end
    for (int j = 0; j < 2*T; j++) begin
      ones_v[j*M +: M] = 10'h001;
      t3_v[j*M +: M]   = 10'(1 << (j + 1));
    end

    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    bus.in_last    = 1'b0;
    bus.syn_ready  = 1'b1;
    bus6.in_valid  = 1'b0;
    bus6.in_data   = '0;
    bus6.in_last   = 1'b0;
    bus6.syn_ready = 1'b1;

    #12;
    check("rst_valid", bus.syn_valid, 0);
    check("rst_data", bus.syn_data, 0);
    check("rst_zero", bus.syn_zero, 0);
    check("rst_err", bus.syn_err, 0);
    check("rst_ready", bus.in_ready, 1);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk); #1;

    fill(8'h00);
    drive_frame(BEATS, 1, 0, -1);
    check("t1_data", bus.syn_data, 0);
    check("t1_zero", bus.syn_zero, 1);
    check("t1_err", bus.syn_err, 0);

    fill(8'h00);
    fr[BEATS-1][7:0] = 8'h80;
    drive_frame(BEATS, 1, 0, -1);
    check("t2_data", bus.syn_data, ones_v);
    check("t2_zero", bus.syn_zero, 0);

    rdy_mode = 0;
    fill(8'h3F);
    fr[BEATS-1][15:8] = 8'hC3;
    drive_frame(BEATS, 1, 0, -1);
    check("t3_data", bus.syn_data, t3_v);
    check("t3_err", bus.syn_err, 0);

    fill(8'h00);
    fr[BEATS-1][7:0] = 8'h80;
    early_stalls = 0;
    fork
      drive_frame(BEATS, 1, 0, -1);
      begin
        n = 0;
        while (cur_beat != BEATS - 1 && n < TMO) begin
          @(negedge clk);
          n++;
        end
        repeat (3) @(negedge clk);
        check("bp_stall", bus.in_ready, 0);
        check("bp_hold", bus.syn_data, t3_v);
        rdy_mode = 1;
      end
    join
    check("bp_early", early_stalls, 0);
    check("bp_new", bus.syn_data, ones_v);

    rdy_mode = 0;
    for (int b = 0; b < BEATS; b++) fr[b] = {$urandom, $urandom};
    drive_frame(6, 1, 0, -1);
    check("t6_err", bus.syn_err, 1);
    fill(8'h00);
    drive_frame(BEATS, 1, 0, 40);
    rstn = 1'b0;
    #1;
    check("mid_rst_valid", bus.syn_valid, 0);
    check("mid_rst_data", bus.syn_data, 0);
    check("mid_rst_err", bus.syn_err, 0);
    check("mid_rst_ready", bus.in_ready, 1);
    exp_q.delete();
    @(negedge clk);
    rstn = 1'b1;
    rdy_mode = 1;
    @(posedge clk); #1;
    fill(8'h00);
    fr[BEATS-1][7:0] = 8'h80;
    drive_frame(BEATS, 1, 0, -1);
    check("t6_clean_data", bus.syn_data, ones_v);
    check("t6_clean_err", bus.syn_err, 0);
    check("t6_clean_zero", bus.syn_zero, 0);

    drive6(64'hFF00_0000_0000_0000, 64'h0);
    check("t4_valid", bus6.syn_valid, 1);
    check("t4_zero", bus6.syn_zero, 1);
    check("t4_data", bus6.syn_data, 0);
    check("t4_err", bus6.syn_err, 0);
    drive6(64'h0, 64'h0000_0000_0000_0080);
    check("t4b_data", bus6.syn_data, 24'h041041);
    check("t4b_zero", bus6.syn_zero, 0);

    rdy_mode = 2;
    for (int f = 0; f < 24; f++) begin
      kind = $urandom_range(3);
      nb   = BEATS;
      last = 1'($urandom);
      if (kind == 0) begin
        fill(8'h00);
        repeat ($urandom_range(3))
          fr[$urandom_range(BEATS-1)][$urandom_range(P-1)*SYM_W+7] = 1'b1;
      end else begin
        for (int b = 0; b < BEATS; b++) fr[b] = {$urandom, $urandom};
      end
      if (kind == 2) nb = $urandom_range(BEATS - 1, 1);
      if (kind == 3) last = 1'b0;
      drive_frame(nb, last, 20, -1);
    end

    rdy_mode = 1;
    n = 0;
    while (exp_q.size() != 0 && n < TMO) begin
      @(posedge clk);
      n++;
    end
    repeat (2) @(posedge clk);
    check("drain", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/bch_syndrome_stream.md
# bch_syndrome_stream

Streaming, parametrised syndrome engine for the BCH decoder datapath. It accepts a codeword as P symbols per beat over a valid/ready handshake and computes S1..S2T over GF(2^M) on the fly by parallel Horner evaluation, so no frame buffer is needed. It outputs all 2T syndromes plus status flags through a one-deep output register. Downstream it feeds the Berlekamp–Massey stage.

## Interface
- M, 10, field degree; GF(2^M).
- PRIM_POLY, 11'h409, primitive polynomial including x^M (x^10+x^3+1).
- N, 1023, codeword length; legal when N ≤ 2^M−1.
- T, 4, correction capability; 2T syndromes are produced.
- P, 8, symbols per beat; P ≥ 1.
- SYM_W, 8, bits per symbol; the hard bit is the symbol MSB (LLR sign); SYM_W=1 is pure hard input.
- clk  in  1  clock.
- rstn  in  1  reset, asynchronous, active-low.
- in_valid  in  1  beat valid.
- in_ready  out  1  beat accepted when in_valid && in_ready.
- in_data  in  P*SYM_W  lane k = in_data[k*SYM_W +: SYM_W]; lane P−1 carries the highest degree.
- in_last  in  1  marks the final beat of a frame.
- syn_valid  out  1  syndrome set available.
- syn_ready  in  1  consumer accepts the set.
- syn_data  out  2T*M  S_j at [(j−1)*M +: M], j=1..2T.
- syn_zero  out  1  all 2T syndromes zero.
- syn_err  out  1  frame length mismatch.

## Operation
- BEATS = ceil(N/P); PAD = BEATS*P − N. The first beat of each frame carries r_{N−1} first. Its top PAD lanes are pad and are masked to 0 regardless of input.
- Per accepted beat, for each j: S_j ← S_j·α^{jP} ⊕ Σ_k b_k·α^{jk}, where b_k is the MSB of lane k. On the first beat the prior S_j is treated as 0, so no clear cycle is needed.
- All multiplications are by constants; the sum uses XOR only. Results are M bits and reduced by PRIM_POLY.
- beat_cnt counts 0..BEATS−1. The frame ends on the first of these two events:
  - in_last accepted;
  - beat_cnt == BEATS−1 accepted.
- syn_err = 1 if in_last arrives before beat BEATS−1, or if beat BEATS−1 arrives without in_last.
- At frame end, the accumulators, syn_zero and syn_err load into the output register, syn_valid sets, and beat_cnt returns to 0.
- Output is held stable while syn_valid && !syn_ready. syn_valid clears on the handshake unless a new frame end loads in the same cycle; in that case the output reloads and syn_valid stays 1.
- in_ready = !(frame-ending beat would be accepted && syn_valid && !syn_ready). Non-final beats are never stalled. The end condition is evaluated with in_last as presented.

## Timing
- Reset values: syn_valid=0, syn_data=0, syn_zero=0, syn_err=0, beat_cnt=0, accumulators=0. in_ready reads 1.
- Throughput: 1 beat/cycle; back-to-back frames run with no bubble.
- Latency: syn_valid rises the cycle after the final beat handshake.
- in_valid low holds all state.
- Reset mid-frame discards the partial frame and any pending output.
- Simultaneous syn_ready and frame end: the old set is consumed and the new set is loaded in the same cycle.

## Structure
- Shared bch_pkg contains:
  - PRIM_POLY constants for M = 6/8/10: 7'h43, 9'h11D, 11'h409;
  - function gf_alpha_pow(e) producing the constant α^e;
  - function gf_const_mul for elaboration-time matrix generation.
- Sub-module bch_gf_const_mul (parameters M, PRIM_POLY, E): combinational multiply by α^E, built as an XOR matrix. It is instantiated 2T·P times plus 2T for the α^{jP} terms.
- Top level contains the beat counter, the accumulator bank, the output register and the handshake logic.

## Test plan
1. Default params, 128 beats of all-zero symbols, last on beat 127 → syn_valid 1 cycle later, syn_data=0, syn_zero=1, syn_err=0.
2. Single error at degree 0 (lane 0 of beat 127 = 8'h80, others 8'h00) → every S_j = 10'h001, syn_zero=0.
3. Soft input, lane 1 of beat 127 = 8'hC3, all others 8'h3F → S1..S8 = 002,004,008,010,020,040,080,100 (hex).
4. M=6, PRIM_POLY=7'h43, N=63, T=2, P=8: pad lane 7 of beat 0 driven to 8'hFF, rest zero → syn_zero=1 (pad masked).
5. Back-pressure: syn_ready=0, second frame streamed → in_ready=0 only on its beat 127, first syndromes unchanged; syn_ready=1 → second set loads and the handshake completes the same cycle.
6. in_last on beat 5 → syn_err=1. Reset asserted at beat 40 of the next frame → all outputs 0. A subsequent clean frame passes scenario 2 exactly.
